// File: rtl/frame_gain_adj_pkg.sv
// Shared constants and types for the frame gain stage and its frame-average producer.
package frame_gain_adj_pkg;
  localparam int         FRAC       = 6;
  localparam logic [7:0] UNITY_GAIN = 8'd64;
  localparam int         DIV_W      = 14;
  localparam int         DEF_W      = 960;
  localparam int         DEF_H      = 540;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_CLAMP
  } fsm_state_t;
endpackage

// File: rtl/frame_gain_adj_div.sv
// Iterative restoring divider, DIV_W-bit numerator by 8-bit denominator, one quotient bit per cycle.
// done is high during the final iteration; quo is valid the cycle after done.
module gain_div_seq
  import frame_gain_adj_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] num,
  input  logic [7:0]       den,
  output logic             done,
  output logic [DIV_W-1:0] quo
);
  localparam int CW = $clog2(DIV_W + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       den_q, den_d;
  logic [8:0]       trial;

  always_comb begin
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    den_d = den_q;
    trial = {rem_q, quo_q[DIV_W-1]};
    if (start) begin
      cnt_d = CW'(DIV_W);
      quo_d = num;
      rem_d = '0;
      den_d = den;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      // remainder stays below den, so the restored difference always fits 8 bits
      if (trial >= {1'b0, den_q}) begin
        rem_d = 8'(trial - {1'b0, den_q});
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = trial[7:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      den_q <= den_d;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign quo  = quo_q;
endmodule

// File: rtl/frame_gain_adj.sv
// Derives gain = TARGET/avg (Q2.6) per frame and applies it to the next frame's pixels, 2-cycle latency.
// Optional GAIN_SMOOTH_EN: pending gain is a 1/4-alpha IIR of the active gain and the new quotient.
module frame_gain_adj
  import frame_gain_adj_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int H      = DEF_H,
  parameter int TARGET = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       avg_valid,
  input  logic [7:0] avg_data,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] gain_out,
  output logic       busy
);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  fsm_state_t       state_q, state_d;
  logic             busy_q, busy_d;
  logic             force_q, force_d;
  logic [7:0]       pending_q, pending_d;
  logic             flag_q, flag_d;
  logic [7:0]       gain_q, gain_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             vld1_q, vld1_d;
  logic [15:0]      prod_q, prod_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;

  logic             div_start, div_done;
  logic [DIV_W-1:0] div_quo;
  logic [7:0]       q_sel, new_gain;
  logic             x_last, y_last, commit;
  logic [16:0]      rnd, scaled;

  gain_div_seq u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (DIV_W'(TARGET << FRAC)),
    .den   (avg_data),
    .done  (div_done),
    .quo   (div_quo)
  );

  assign div_start = (state_q == ST_IDLE) && avg_valid && (avg_data != 8'd0);
  assign q_sel     = (force_q || (|div_quo[DIV_W-1:8])) ? 8'hFF : div_quo[7:0];

`ifdef GAIN_SMOOTH_EN
  logic [9:0] smooth_sum;
  assign smooth_sum = 10'd3 * {2'b00, gain_q} + {2'b00, q_sel} + 10'd2;
  assign new_gain   = smooth_sum[9:2];
`else
  assign new_gain   = q_sel;
`endif

  assign x_last = (x_q == XW'(W - 1));
  assign y_last = (y_q == YW'(H - 1));
  // Swap gains only on the last pixel or while the stream sits idle at frame start.
  assign commit = flag_q && ((pix_valid && x_last && y_last) ||
                             (!pix_valid && (x_q == '0) && (y_q == '0)));

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    force_d   = force_q;
    pending_d = pending_q;
    flag_d    = flag_q;
    gain_d    = gain_q;
    if (commit) begin
      gain_d = pending_q;
      flag_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (avg_valid) begin
          busy_d  = 1'b1;
          force_d = (avg_data == 8'd0);
          state_d = (avg_data == 8'd0) ? ST_CLAMP : ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_CLAMP;
      end
      ST_CLAMP: begin
        pending_d = new_gain;
        flag_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_valid) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    vld1_d      = pix_valid;
    prod_d      = 16'(pix_data) * 16'(gain_q);
    rnd         = {1'b0, prod_q} + 17'd32;
    scaled      = rnd >> FRAC;
    out_valid_d = vld1_q;
    out_data_d  = out_data_q;
    if (vld1_q) out_data_d = (|scaled[16:8]) ? 8'hFF : scaled[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      force_q     <= 1'b0;
      pending_q   <= UNITY_GAIN;
      flag_q      <= 1'b0;
      gain_q      <= UNITY_GAIN;
      x_q         <= '0;
      y_q         <= '0;
      vld1_q      <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      force_q     <= force_d;
      pending_q   <= pending_d;
      flag_q      <= flag_d;
      gain_q      <= gain_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vld1_q      <= vld1_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign gain_out  = gain_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_frame_gain_adj.sv
// Directed bench for frame_gain_adj using a 4x2 frame so frame boundaries are reached quickly.
module tb_frame_gain_adj;
  logic       clk;
  logic       rst;
  logic       avg_valid;
  logic [7:0] avg_data;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] gain_out;
  logic       busy;

  int tests_run;
  int tests_failed;

`ifdef GAIN_SMOOTH_EN
  localparam logic [7:0] G_AVG64  = 8'd80;
  localparam logic [7:0] G_AVG200 = 8'd58;
  localparam logic [7:0] G_AVG0   = 8'd112;
  localparam logic [7:0] G_AVG32  = 8'd112;
  localparam logic [7:0] P200_G64 = 8'd250;
  localparam logic [7:0] P50_G64  = 8'd63;
  localparam logic [7:0] P100_G200 = 8'd91;
  localparam logic [7:0] P1_G0    = 8'd2;
  localparam logic [7:0] B2B_EXP [5] = '{8'd0, 8'd231, 8'd91, 8'd58, 8'd1};
`else
  localparam logic [7:0] G_AVG64  = 8'd128;
  localparam logic [7:0] G_AVG200 = 8'd40;
  localparam logic [7:0] G_AVG0   = 8'd255;
  localparam logic [7:0] G_AVG32  = 8'd255;
  localparam logic [7:0] P200_G64 = 8'd255;
  localparam logic [7:0] P50_G64  = 8'd100;
  localparam logic [7:0] P100_G200 = 8'd63;
  localparam logic [7:0] P1_G0    = 8'd4;
  localparam logic [7:0] B2B_EXP [5] = '{8'd0, 8'd159, 8'd63, 8'd40, 8'd1};
`endif
  localparam logic [7:0] B2B_IN [5] = '{8'd0, 8'd255, 8'd100, 8'd64, 8'd1};

  frame_gain_adj #(.W(4), .H(2), .TARGET(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .avg_valid (avg_valid),
    .avg_data  (avg_data),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gain_out  (gain_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    avg_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Returns at the negedge where this pixel's result is visible.
  task automatic drive_pix(input logic [7:0] v);
    pix_valid = 1'b1;
    pix_data  = v;
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_avg(input logic [7:0] v);
    avg_valid = 1'b1;
    avg_data  = v;
    tick();
    avg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests_run++;
    if (gain_out !== 8'd64) begin tests_failed++; $display("FAIL reset_gain: got %0d expected 64", gain_out); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (out_data !== 8'd0) begin tests_failed++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    rst = 1'b0;
    tick();
    pix_valid = 1'b1;
    pix_data  = 8'd100;
    tick();
    pix_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL latency_early: out_valid %b after 1 cycle, expected 0", out_valid); end
    tick();
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL latency_valid: out_valid %b after 2 cycles, expected 1", out_valid); end
    tests_run++;
    if (out_data !== 8'd100) begin tests_failed++; $display("FAIL unity_pix100: got %0d expected 100", out_data); end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL valid_drop: out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_frame_commit();
    do_reset();
    drive_pix(8'd10);
    tests_run++;
    if (out_data !== 8'd10) begin tests_failed++; $display("FAIL frame_pix10: got %0d expected 10", out_data); end
    pulse_avg(8'd64);
    repeat (20) tick();
    tests_run++;
    if (gain_out !== 8'd64) begin tests_failed++; $display("FAIL midframe_hold: gain %0d expected 64", gain_out); end
    for (int i = 0; i < 6; i++) drive_pix(8'd20);
    tests_run++;
    if (gain_out !== 8'd64) begin tests_failed++; $display("FAIL before_last_hold: gain %0d expected 64", gain_out); end
    drive_pix(8'd100);
    tests_run++;
    if (out_data !== 8'd100) begin tests_failed++; $display("FAIL last_pix_old_gain: got %0d expected 100", out_data); end
    tests_run++;
    if (gain_out !== G_AVG64) begin tests_failed++; $display("FAIL frame_commit_gain: got %0d expected %0d", gain_out, G_AVG64); end
    drive_pix(8'd200);
    tests_run++;
    if (out_data !== P200_G64) begin tests_failed++; $display("FAIL pix200_sat: got %0d expected %0d", out_data, P200_G64); end
    drive_pix(8'd50);
    tests_run++;
    if (out_data !== P50_G64) begin tests_failed++; $display("FAIL pix50: got %0d expected %0d", out_data, P50_G64); end
  endtask

  task automatic test_div_200();
    int n;
    do_reset();
    pulse_avg(8'd200);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    tests_run++;
    if (n != 15) begin tests_failed++; $display("FAIL busy_len_200: got %0d cycles expected 15", n); end
    tick();
    tests_run++;
    if (gain_out !== G_AVG200) begin tests_failed++; $display("FAIL gain_avg200: got %0d expected %0d", gain_out, G_AVG200); end
    drive_pix(8'd100);
    tests_run++;
    if (out_data !== P100_G200) begin tests_failed++; $display("FAIL pix100_g200: got %0d expected %0d", out_data, P100_G200); end
  endtask

  task automatic test_div_zero_and_clamp();
    int n;
    do_reset();
    pulse_avg(8'd0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    tests_run++;
    if (n != 1) begin tests_failed++; $display("FAIL busy_len_avg0: got %0d cycles expected 1", n); end
    tick();
    tests_run++;
    if (gain_out !== G_AVG0) begin tests_failed++; $display("FAIL gain_avg0: got %0d expected %0d", gain_out, G_AVG0); end
    drive_pix(8'd1);
    tests_run++;
    if (out_data !== P1_G0) begin tests_failed++; $display("FAIL pix1_gmax: got %0d expected %0d", out_data, P1_G0); end
    do_reset();
    pulse_avg(8'd32);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    tests_run++;
    if (n != 15) begin tests_failed++; $display("FAIL busy_len_32: got %0d cycles expected 15", n); end
    tick();
    tests_run++;
    if (gain_out !== G_AVG32) begin tests_failed++; $display("FAIL gain_avg32_clamp: got %0d expected %0d", gain_out, G_AVG32); end
  endtask

  task automatic test_ignore_busy();
    int n;
    do_reset();
    pulse_avg(8'd200);
    repeat (3) tick();
    pulse_avg(8'd0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    tests_run++;
    if (n != 11) begin tests_failed++; $display("FAIL busy_remaining: got %0d cycles expected 11", n); end
    repeat (3) tick();
    tests_run++;
    if (gain_out !== G_AVG200) begin tests_failed++; $display("FAIL ignore_busy_gain: got %0d expected %0d", gain_out, G_AVG200); end
  endtask

  task automatic test_reset_mid_div();
    pulse_avg(8'd64);
    repeat (4) tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL div_busy_before_rst: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    tests_run++;
    if (gain_out !== 8'd64) begin tests_failed++; $display("FAIL rst_mid_gain: got %0d expected 64", gain_out); end
    tick();
    rst = 1'b0;
    repeat (25) tick();
    tests_run++;
    if (gain_out !== 8'd64) begin tests_failed++; $display("FAIL rst_no_commit: got %0d expected 64", gain_out); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_stays_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_avg(8'd200);
    repeat (20) tick();
    tests_run++;
    if (gain_out !== G_AVG200) begin tests_failed++; $display("FAIL b2b_gain: got %0d expected %0d", gain_out, G_AVG200); end
    for (int i = 0; i < 7; i++) begin
      pix_valid = (i < 5);
      pix_data  = (i < 5) ? B2B_IN[i] : 8'hAA;
      tick();
      if (i >= 1 && i <= 5) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== B2B_EXP[i-1]) begin
          tests_failed++;
          $display("FAIL b2b_pix%0d: valid %b data %0d expected valid 1 data %0d", i - 1, out_valid, out_data, B2B_EXP[i-1]);
        end
      end
    end
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== B2B_EXP[4]) begin
      tests_failed++;
      $display("FAIL b2b_hold: valid %b data %0d expected valid 0 data %0d", out_valid, out_data, B2B_EXP[4]);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    avg_valid    = 1'b0;
    avg_data     = 8'd0;
    pix_valid    = 1'b0;
    pix_data     = 8'd0;
    test_reset();
    test_frame_commit();
    test_div_200();
    test_div_zero_and_clamp();
    test_ignore_busy();
    test_reset_mid_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/frame_gain_adj.md
Name: frame_gain_adj

Overview:
- Downstream consumer of the frame-average stage: takes the per-frame 8-bit average luma and derives a Q2.6 brightness gain, gain = TARGET/avg.
- Applies that gain to the following frame's 8-bit pixel stream with rounding and saturation.
- Gain updates only at frame boundaries, so one frame never mixes two gains.

Parameters:
- W, 960, active pixels per line.
- H, 540, active lines per frame.
- TARGET, 128, desired average luma (1..255).
- FRAC, 6, gain fractional bits (gain is 8-bit Q2.6, so 64 = 1.0).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- avg_valid  in  1  one-cycle pulse, frame average available
- avg_data  in  8  frame average luma
- pix_valid  in  1  input pixel qualifier
- pix_data  in  8  input pixel luma
- out_valid  out  1  output pixel qualifier
- out_data  out  8  gain-adjusted pixel
- gain_out  out  8  currently active gain, Q2.6
- busy  out  1  divider running

Behaviour:
- Reset values: out_valid=0, out_data=0, gain_out=64, busy=0. Pending gain is cleared, FSM is IDLE, x/y counters are 0.
- FSM states: IDLE, DIV, CLAMP.
  - IDLE: on avg_valid, latch avg_data.
    - If avg_data==0: go to CLAMP with quotient forced to 255.
    - Otherwise: load numerator TARGET<<FRAC (14 bits) and denominator avg_data, then go to DIV.
  - DIV: restoring shift-subtract divider, one quotient bit per cycle, 14 cycles, truncating.
  - CLAMP: quotient>255 gives 255, else quotient[7:0]. Write the pending gain, set pending_flag=1, go to IDLE.
- Timing: busy=1 in DIV and CLAMP. With avg_valid in cycle 0, pending_flag is set at the end of cycle 15 (or cycle 1 for avg=0).
- avg_valid while busy is ignored; no queuing.
- A new result while pending_flag=1 overwrites the pending gain.
- Pixel counters: x increments on pix_valid and wraps at W-1, which increments y; y wraps at H-1.
- Gain commit (gain_out <= pending, pending_flag <= 0) happens when either:
  - pix_valid is high on x==W-1, y==H-1 (last pixel; the new gain takes effect from the next frame's first pixel), or
  - pending_flag=1, x==0, y==0 and pix_valid=0 (idle between frames).
- Pixel pipeline, fixed latency 2 cycles:
  - Stage 1: prod = pix_data * gain_out (16 bits).
  - Stage 2: (prod + 32) >> FRAC; result >255 saturates to 255.
  - out_valid is pix_valid delayed 2 cycles. out_data holds its value when out_valid=0.
- Reset mid-division aborts the divide. Pending gain is discarded and the active gain returns to 64.

Optional Feature:
- Macro GAIN_SMOOTH_EN.
- When defined: CLAMP writes pending = (3*gain_out + q + 2) >> 2 (IIR, alpha 1/4), using a 10-bit intermediate.
- When undefined: pending = q directly.

Decomposition:
- Shared package holds:
  - FRAC and the unity-gain constant (64).
  - The FSM state enum.
  - The divider width constant (14).
  - Default W/H, shared with the frame-average stage.
- One sub-module, gain_div_seq: the iterative 14-bit/8-bit restoring divider with start/done handshake. The FSM, counters and pixel pipeline stay in the top module.

Test Plan:
- Reset: after rst, gain_out=64 and out_valid=0. Pixel 100 yields out_data=100 exactly 2 cycles later.
- avg=64 during a frame: gain_out stays 64 until that frame's last pixel, then 128 from the next frame. Pixel 200 gives 255 (saturated), pixel 50 gives 100.
- avg=200: gain 40. Pixel 100 gives 63. busy is high for exactly 15 cycles.
- avg=0: gain 255, busy for 1 cycle. avg=32: quotient 256 clamps to 255.
- Second avg_valid while busy is ignored. rst asserted in DIV cycle 5 returns gain_out to 64 and busy to 0 with no commit.
- With GAIN_SMOOTH_EN, active gain 64 and avg=64: the committed gain is 80.
